// File: rtl/zsy_seg7_pkg.sv
// Shared definitions for the 7-segment reader: segment codes (common with the
// display driver), FSM state encoding and the decoded-pattern record.
package zsy_seg7_pkg;

    // Segment order is {a,b,c,d,e,f,g}, active high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] hex;
        logic       blank;
        logic       err;
    } dec_t;

endpackage

// File: rtl/zsy_seg7_to_hex.sv
// Combinational inverse of the display driver's segment table.
// Blank and unknown patterns both decode to nibble 0 and are told apart by the flags.
module zsy_seg7_to_hex
    import zsy_seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_hex,
    output logic       o_blank,
    output logic       o_err
);

    always_comb begin
        o_hex   = 4'h0;
        o_blank = 1'b0;
        o_err   = 1'b0;
        case (i_seg)
            SEG_0:     o_hex = 4'h0;
            SEG_1:     o_hex = 4'h1;
            SEG_2:     o_hex = 4'h2;
            SEG_3:     o_hex = 4'h3;
            SEG_4:     o_hex = 4'h4;
            SEG_5:     o_hex = 4'h5;
            SEG_6:     o_hex = 4'h6;
            SEG_7:     o_hex = 4'h7;
            SEG_8:     o_hex = 4'h8;
            SEG_9:     o_hex = 4'h9;
            SEG_A:     o_hex = 4'hA;
            SEG_B:     o_hex = 4'hB;
            SEG_C:     o_hex = 4'hC;
            SEG_D:     o_hex = 4'hD;
            SEG_E:     o_hex = 4'hE;
            SEG_F:     o_hex = 4'hF;
            SEG_BLANK: o_blank = 1'b1;
            default:   o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/zsy_seg7_reader.sv
// Snoops a multiplexed 7-segment bus, debounces each digit's pattern, and
// publishes a full frame of decoded digits with a one-cycle frame_valid strobe.
module zsy_seg7_reader
    import zsy_seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  frame_valid,
    output state_t                dbg_state
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT - 1);

    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_sel;
    logic              r_en;
    logic [3:0]        r_cnt;
    logic              r_acc;
    state_t            r_state;
    state_t            w_next;
    logic [DIGITS-1:0] r_mask;
    logic [3:0]        r_slot_hex [DIGITS];
    logic [DIGITS-1:0] r_slot_blank;
    logic [DIGITS-1:0] r_slot_err;

    logic   w_same;
    logic   w_onehot;
    logic   w_accept;
    logic   w_full;
    logic   w_publish;
    dec_t   w_dec;

    // The counter measures how long the registered sample has been stable,
    // so it compares the incoming sample against the one already held.
    assign w_same    = ({seg, dig_sel} == {r_seg, r_sel});
    assign w_onehot  = $onehot(r_sel);
    assign w_full    = &r_mask;
    assign w_accept  = (r_state == ST_COLLECT) && r_en && (r_cnt == CNT_MAX)
                       && !r_acc && w_onehot;
    assign w_publish = (w_next == ST_PUBLISH);
    assign dbg_state = r_state;

    zsy_seg7_to_hex u_dec (
        .i_seg   (r_seg),
        .o_hex   (w_dec.hex),
        .o_blank (w_dec.blank),
        .o_err   (w_dec.err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_sel <= '0;
            r_en  <= 1'b0;
            r_cnt <= '0;
            r_acc <= 1'b0;
        end else begin
            r_seg <= seg;
            r_sel <= dig_sel;
            r_en  <= en;
            if (!w_same) begin
                r_cnt <= '0;
                r_acc <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 4'd1;
                if (w_accept)
                    r_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (r_en) w_next = ST_COLLECT;
            ST_COLLECT: if (w_full) w_next = ST_PUBLISH;
            ST_PUBLISH: w_next = ST_COLLECT;
            default:    w_next = ST_IDLE;
        endcase
        if (!r_en)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask       <= '0;
            r_slot_blank <= '0;
            r_slot_err   <= '0;
            for (int i = 0; i < DIGITS; i++)
                r_slot_hex[i] <= 4'h0;
        end else begin
            if (!r_en || r_state == ST_PUBLISH)
                r_mask <= '0;
            else if (w_accept)
                r_mask <= r_mask | r_sel;
            for (int i = 0; i < DIGITS; i++) begin
                if (w_accept && r_sel[i]) begin
                    r_slot_hex[i]   <= w_dec.hex;
                    r_slot_blank[i] <= w_dec.blank;
                    r_slot_err[i]   <= w_dec.err;
                end
            end
        end
    end

    // Outputs only change on the publish edge so a consumer always sees a whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value       <= '0;
            blank_mask  <= '0;
            err_mask    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= w_publish;
            if (w_publish) begin
                blank_mask <= r_slot_blank;
                err_mask   <= r_slot_err;
                for (int i = 0; i < DIGITS; i++)
                    value[4*i +: 4] <= r_slot_hex[i];
            end
        end
    end

endmodule

// File: tb/tb_zsy_seg7_reader.sv
// Directed bench for zsy_seg7_reader (DIGITS=4, STABLE_CNT=4): inputs change on
// the falling edge, outputs are checked on the falling edge.
module tb_zsy_seg7_reader;
    import zsy_seg7_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        frame_valid;
    state_t      dbg_state;

    int checks   = 0;
    int failures = 0;

    int          fv_count = 0;
    logic [15:0] last_value = '0;
    logic [3:0]  last_blank = '0;
    logic [3:0]  last_err   = '0;
    logic        saw_nib0_one = 1'b0;
    int          base;

    zsy_seg7_reader #(.DIGITS(4), .STABLE_CNT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .value       (value),
        .blank_mask  (blank_mask),
        .err_mask    (err_mask),
        .frame_valid (frame_valid),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame monitor: records every published frame just after the edge that made it.
    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) begin
            fv_count++;
            last_value = value;
            last_blank = blank_mask;
            last_err   = err_mask;
            if (value[3:0] == 4'h1)
                saw_nib0_one = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [6:0] p, input int n);
        dig_sel = s;
        seg     = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(4'b0000, 7'h00, n);
    endtask

    initial begin
        // 1: reset with random bus activity
        rst_n   = 1'b0;
        en      = 1'b1;
        seg     = 7'($urandom_range(0, 127));
        dig_sel = 4'($urandom_range(0, 15));
        @(negedge clk);
        seg     = 7'($urandom_range(0, 127));
        dig_sel = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("rst_value", 32'(value), 32'h0);
        check("rst_blank", 32'(blank_mask), 32'h0);
        check("rst_err", 32'(err_mask), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_fv_count", 32'(fv_count), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // 2: basic frame 0B43
        base = fv_count;
        drive(4'b0001, 7'h79, 4);
        drive(4'b0010, 7'h33, 4);
        drive(4'b0100, 7'h1F, 4);
        drive(4'b1000, 7'h7E, 4);
        idle(4);
        check("basic_pulses", 32'(fv_count - base), 32'd1);
        check("basic_value", 32'(last_value), 32'h0B43);
        check("basic_blank", 32'(last_blank), 32'h0);
        check("basic_err", 32'(last_err), 32'h0);
        check("basic_fv_low", 32'(frame_valid), 32'h0);
        check("basic_hold", 32'(value), 32'h0B43);

        // 3: 3-cycle glitch is too short, the following 8 wins
        base = fv_count;
        drive(4'b0001, 7'h30, 3);
        drive(4'b0001, 7'h7F, 4);
        drive(4'b0010, 7'h5B, 4);
        drive(4'b0100, 7'h4E, 4);
        drive(4'b1000, 7'h3D, 4);
        idle(4);
        check("glitch_pulses", 32'(fv_count - base), 32'd1);
        check("glitch_value", 32'(last_value), 32'hDC58);
        check("glitch_never1", 32'(saw_nib0_one), 32'h0);

        // 4: blank and undecodable positions
        base = fv_count;
        drive(4'b0001, 7'h5B, 4);
        drive(4'b0100, 7'h01, 4);
        drive(4'b0010, 7'h00, 4);
        drive(4'b1000, 7'h7B, 4);
        idle(4);
        check("flags_pulses", 32'(fv_count - base), 32'd1);
        check("flags_value", 32'(last_value), 32'h9005);
        check("flags_blank", 32'(last_blank), 32'b0010);
        check("flags_err", 32'(last_err), 32'b0100);

        // 5: multi-hot never captures; en drop discards partial frame
        base = fv_count;
        drive(4'b0011, 7'h7E, 10);
        drive(4'b0100, 7'h30, 4);
        drive(4'b1000, 7'h30, 4);
        idle(4);
        check("multihot_no_frame", 32'(fv_count - base), 32'd0);
        idle(2);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        idle(3);
        drive(4'b0001, 7'h5F, 4);
        drive(4'b0010, 7'h70, 4);
        idle(4);
        check("en_drop_no_frame", 32'(fv_count - base), 32'd0);
        drive(4'b0100, 7'h77, 4);
        drive(4'b1000, 7'h4F, 4);
        idle(4);
        check("en_drop_pulses", 32'(fv_count - base), 32'd1);
        check("en_drop_value", 32'(last_value), 32'hEA76);

        // 6: reset mid-frame
        drive(4'b0001, 7'h30, 4);
        drive(4'b0010, 7'h6D, 4);
        drive(4'b0100, 7'h79, 4);
        idle(2);
        rst_n = 1'b0;
        idle(2);
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_blank", 32'(blank_mask), 32'h0);
        check("midrst_err", 32'(err_mask), 32'h0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        idle(2);
        base = fv_count;
        drive(4'b1000, 7'h33, 4);
        idle(4);
        check("midrst_no_frame", 32'(fv_count - base), 32'd0);
        drive(4'b0001, 7'h30, 4);
        drive(4'b0010, 7'h6D, 4);
        drive(4'b0100, 7'h79, 4);
        idle(4);
        check("midrst_pulses", 32'(fv_count - base), 32'd1);
        check("midrst_frame", 32'(last_value), 32'h4321);
        check("midrst_out", 32'(value), 32'h4321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
